sram_march_bist: RTL
====================

SRAM_MARCH_BIST -- requirements
Module: sram_march_bist

Interface
- REQ-001: Parameter ADDR_W, default 14, address width; word count N = 2^ADDR_W.
- REQ-002: Parameter DATA_W, default 32, memory word width.
- REQ-003: Parameter PATTERN, default 32'hA5A5_5A5A, background pattern P; ~P is its bitwise inverse.
- REQ-004: clk  input  1  single clock; all state changes on the rising edge.
- REQ-005: rst_n  input  1  asynchronous, active-low reset.
- REQ-006: start  input  1  request to run the test; sampled only in IDLE.
- REQ-007: mem_we  output  1  write enable to the SRAM.
- REQ-008: mem_addr  output  ADDR_W  SRAM address.
- REQ-009: mem_data_in  output  DATA_W  SRAM write data.
- REQ-010: mem_data_out  input  DATA_W  SRAM read data, valid one cycle after the address is presented with mem_we=0.
- REQ-011: busy  output  1  test in progress.
- REQ-012: done  output  1  one-cycle pulse at test end.
- REQ-013: pass  output  1  result of the last completed test; 1 = no mismatch.
- REQ-014: fail_addr  output  ADDR_W  address of the first mismatch.
- REQ-015: fail_data  output  DATA_W  data observed at the first mismatch.

Function
- REQ-016: All outputs SHALL be driven from registers.
- REQ-017: States SHALL be IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_CHK.
- REQ-018: When start=1 is sampled in IDLE, the block SHALL enter M0_W with address 0 and assert busy from the next cycle.
- REQ-019: A start received while busy=1 SHALL be ignored.
- REQ-020: M0_W (ascending) SHALL write P to each address, 1 cycle per address.
- REQ-021: M1 (ascending) SHALL take 2 cycles per address.
  - M1_R issues a read (mem_we=0).
  - M1_W compares mem_data_out against P and, in the same cycle, writes ~P to the same address.
- REQ-022: M2 (descending, N-1 down to 0) SHALL work like M1, expecting ~P and writing P.
- REQ-023: M3_R (descending) SHALL issue one read per cycle and compare each read one cycle later, while issuing the next address.
- REQ-024: After the address-0 read in M3_R, the block SHALL enter M3_CHK for a final compare cycle.
- REQ-025: A fault-free run SHALL hold busy=1 for exactly 6N+1 cycles.
- REQ-026: In the cycle after a fault-free run, the block SHALL set busy=0, pulse done=1 and set pass=1, then return to IDLE.
- REQ-027: Address counters SHALL NOT wrap.
  - Ascending elements end at N-1.
  - Descending elements end at 0.
  - Each transition at these bounds SHALL go directly to the next element.
- REQ-028: On the first mismatch, the block SHALL do all of the following:
  - suppress that cycle's write (mem_we=0);
  - capture fail_addr and fail_data;
  - in the next cycle, set busy=0, pulse done=1, set pass=0 and return to IDLE.
- REQ-029: pass, fail_addr and fail_data SHALL hold their values until the next accepted start.
- REQ-030: An accepted start SHALL clear pass, fail_addr and fail_data to 0.
- REQ-031: In IDLE, mem_we SHALL be 0, and mem_addr and mem_data_in SHALL hold their last values.

Reset
- REQ-032: While rst_n=0, the block SHALL immediately force the following, asynchronously:
  - state = IDLE;
  - mem_we, busy, done and pass = 0;
  - mem_addr, mem_data_in, fail_addr and fail_data = 0.
- REQ-033: Reset asserted mid-test SHALL abort the test with no further writes, and no done pulse SHALL follow.
- REQ-034: After reset release, the block SHALL wait in IDLE for start.

Verification (ADDR_W=4, N=16, behavioural SRAM model with 1-cycle read)
- REQ-035: Fault-free run: start pulse -> busy high for exactly 97 cycles, then done pulse with pass=1; every model word ends as 32'hA5A5_5A5A.
- REQ-036: Stuck-at-0 fault on bit 0 of address 5 -> mismatch in M2 -> fail_addr=5, fail_data=32'h5A5A_A5A4, pass=0; no write to address 5 in the mismatch cycle; done pulses next cycle.
- REQ-037: Address fault (writes to address 3 also corrupt address 12) -> pass=0 with fail_addr=12 or fail_addr=3 per the model's mismatch order; the test stops at the first mismatch.
- REQ-038: start held high for the entire run -> exactly one run executes per IDLE entry; a second run begins the cycle after done.
- REQ-039: rst_n pulsed low during M2 -> all outputs 0 immediately, no done pulse, mem_we stays 0; a subsequent start runs a full 97-cycle pass.

Source files
------------

// File: rtl/sram_march_bist.sv
// Word-oriented March self-test: {w P}up {r P, w ~P}up {r ~P, w P}down {r P}down.
// SRAM port outputs are registered, so the access chosen in a state reaches the SRAM one cycle later.
module sram_march_bist #(
  parameter int unsigned       ADDR_W  = 14,
  parameter int unsigned       DATA_W  = 32,
  parameter logic [DATA_W-1:0] PATTERN = DATA_W'(32'hA5A5_5A5A)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    IDLE, M0_W, M1_R, M1_W, M2_R, M2_W, M3_R, M3_CHK
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_data_in_q, mem_data_in_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_W-1:0]   fail_data_q, fail_data_d;
  logic                cmp_en;
  logic [DATA_W-1:0]   cmp_exp;
  logic                mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_data_in_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_addr_q   <= '0;
      fail_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_data_in_q <= mem_data_in_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_addr_q   <= fail_addr_d;
      fail_data_q   <= fail_data_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_data_in_d = mem_data_in_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    fail_addr_d   = fail_addr_q;
    fail_data_d   = fail_data_q;
    cmp_en        = 1'b0;
    cmp_exp       = PATTERN;

    // Read data on the port belongs to the address currently driven on mem_addr.
    unique case (state_q)
      M1_W:    cmp_en = 1'b1;
      M2_W: begin
        cmp_en  = 1'b1;
        cmp_exp = ~PATTERN;
      end
      M3_R:    cmp_en = (addr_q != ADDR_MAX);
      M3_CHK:  cmp_en = 1'b1;
      default: cmp_en = 1'b0;
    endcase
    mismatch = cmp_en && (mem_data_out != cmp_exp);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = M0_W;
          addr_d      = ADDR_ZERO;
          busy_d      = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
        end
      end
      M0_W: begin
        mem_we_d      = 1'b1;
        mem_addr_d    = addr_q;
        mem_data_in_d = PATTERN;
        if (addr_q == ADDR_MAX) begin
          state_d = M1_R;
          addr_d  = ADDR_ZERO;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      M1_R: begin
        mem_addr_d = addr_q;
        state_d    = M1_W;
      end
      M1_W: begin
        mem_we_d      = 1'b1;
        mem_addr_d    = addr_q;
        mem_data_in_d = ~PATTERN;
        if (addr_q == ADDR_MAX) begin
          state_d = M2_R;
        end else begin
          state_d = M1_R;
          addr_d  = addr_q + ADDR_ONE;
        end
      end
      M2_R: begin
        mem_addr_d = addr_q;
        state_d    = M2_W;
      end
      M2_W: begin
        mem_we_d      = 1'b1;
        mem_addr_d    = addr_q;
        mem_data_in_d = PATTERN;
        if (addr_q == ADDR_ZERO) begin
          state_d = M3_R;
          addr_d  = ADDR_MAX;
        end else begin
          state_d = M2_R;
          addr_d  = addr_q - ADDR_ONE;
        end
      end
      M3_R: begin
        mem_addr_d = addr_q;
        if (addr_q == ADDR_ZERO) begin
          state_d = M3_CHK;
        end else begin
          addr_d = addr_q - ADDR_ONE;
        end
      end
      M3_CHK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // First mismatch: drop the pending access, record it and finish.
    if (mismatch) begin
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_data_in_d = mem_data_in_q;
      state_d       = IDLE;
      busy_d        = 1'b0;
      done_d        = 1'b1;
      pass_d        = 1'b0;
      fail_addr_d   = mem_addr_q;
      fail_data_d   = mem_data_out;
    end
  end

  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_data_in = mem_data_in_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_addr   = fail_addr_q;
  assign fail_data   = fail_data_q;

endmodule
